// File: rtl/bht_predictor_if.sv
// Lookup/update bundle for bht_predictor.
// master: frontend and branch unit side. slave: the predictor.
interface bht_predictor_if #(
   parameter int unsigned VLEN = 32
);
   logic            flush_i;
   logic            debug_mode_i;
   logic [VLEN-1:0] vpc_i;
   logic            bht_valid_o;
   logic            bht_taken_o;
   logic            upd_valid_i;
   logic [VLEN-1:0] upd_pc_i;
   logic            upd_conditional_i;
   logic            upd_taken_i;
   logic            ready_o;

   modport master (
      output flush_i, debug_mode_i, vpc_i,
      output upd_valid_i, upd_pc_i, upd_conditional_i, upd_taken_i,
      input  bht_valid_o, bht_taken_o, ready_o
   );

   modport slave (
      input  flush_i, debug_mode_i, vpc_i,
      input  upd_valid_i, upd_pc_i, upd_conditional_i, upd_taken_i,
      output bht_valid_o, bht_taken_o, ready_o
   );
endinterface

// File: rtl/bht_predictor.sv
// Branch history table of 2-bit saturating counters with a clear sweep and a one-stage update pipeline.
// Define BHT_BYPASS_EN to forward the committing update to a same-index lookup.
module bht_predictor #(
   parameter int unsigned NR_ENTRIES = 64,
   parameter int unsigned VLEN       = 32
) (
   input logic            clk_i,
   input logic            rst_i,
   bht_predictor_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

   typedef enum logic {INIT, RUN} state_t;

   state_t           state;
   logic [IDX_W-1:0] sweep;
   logic             stage_valid;
   logic             stage_taken;
   logic [IDX_W-1:0] stage_idx;

   logic [NR_ENTRIES-1:0] valid_q;
   logic [1:0]            cnt_q [NR_ENTRIES];

   logic             run;
   logic             capture;
   logic             commit;
   logic [IDX_W-1:0] lookup_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [1:0]       new_cnt;
   logic             hit_valid;
   logic [1:0]       hit_cnt;
   logic             unused_pc;

   // Bit 0 is dropped: compressed instructions are 2-byte aligned.
   assign lookup_idx = bus.vpc_i[IDX_W:1];
   assign upd_idx    = bus.upd_pc_i[IDX_W:1];
   assign unused_pc  = ^{bus.vpc_i[VLEN-1:IDX_W+1], bus.vpc_i[0],
                         bus.upd_pc_i[VLEN-1:IDX_W+1], bus.upd_pc_i[0]};

   assign run     = (state == RUN);
   assign capture = bus.upd_valid_i & bus.upd_conditional_i & ~bus.debug_mode_i
                  & run & ~bus.flush_i & ~rst_i;
   assign commit  = stage_valid & run & ~bus.flush_i & ~rst_i;

   always_comb begin
      new_cnt = cnt_q[stage_idx];
      if (stage_taken) begin
         if (new_cnt != 2'b11) new_cnt = new_cnt + 2'b01;
      end else begin
         if (new_cnt != 2'b00) new_cnt = new_cnt - 2'b01;
      end
   end

   always_comb begin
      hit_valid = valid_q[lookup_idx];
      hit_cnt   = cnt_q[lookup_idx];
`ifdef BHT_BYPASS_EN
      if (commit && (lookup_idx == stage_idx)) begin
         hit_valid = 1'b1;
         hit_cnt   = new_cnt;
      end
`endif
   end

   assign bus.ready_o     = run;
   assign bus.bht_valid_o = hit_valid & run;
   assign bus.bht_taken_o = hit_cnt[1] & bus.bht_valid_o;

   always_ff @(posedge clk_i) begin
      if (rst_i || bus.flush_i) begin
         state       <= INIT;
         sweep       <= '0;
         stage_valid <= 1'b0;
      end else begin
         stage_valid <= capture;
         if (capture) begin
            stage_idx   <= upd_idx;
            stage_taken <= bus.upd_taken_i;
         end
         if (state == INIT) begin
            sweep <= sweep + 1'b1;
            if (sweep == IDX_W'(NR_ENTRIES - 1)) state <= RUN;
         end
      end
   end

   // Table storage has no reset; the INIT sweep is what clears it.
   always_ff @(posedge clk_i) begin
      if (state == INIT) begin
         valid_q[sweep] <= 1'b0;
         cnt_q[sweep]   <= 2'b01;
      end else if (commit) begin
         valid_q[stage_idx] <= 1'b1;
         cnt_q[stage_idx]   <= new_cnt;
      end
   end
endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench for bht_predictor: a per-cycle reference model queues expected lookups, a monitor compares them.
module tb_bht_predictor;
   localparam int NR   = 64;
   localparam int VLEN = 32;

   typedef struct {
      int at;
      int idx;
      bit taken;
   } pend_t;

   typedef struct {
      bit r;
      bit v;
      bit t;
   } exp_t;

   logic clk;
   logic rst;
   bht_predictor_if #(.VLEN(VLEN)) bus ();

   bht_predictor #(.NR_ENTRIES(NR), .VLEN(VLEN)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   int    init_left;
   int    cnt_m [NR];
   bit    valid_m [NR];
   pend_t pend_q [$];
   exp_t  exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   function automatic int sat(input int c, input bit t);
      if (t) return (c < 3) ? c + 1 : 3;
      return (c > 0) ? c - 1 : 0;
   endfunction

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 1) % NR);
   endfunction

   task automatic model_clear();
      init_left = NR;
      pend_q.delete();
      for (int i = 0; i < NR; i++) begin
         valid_m[i] = 1'b0;
         cnt_m[i]   = 1;
      end
   endtask

   // Drive one cycle, queue the expected lookup, then advance the model across the clock edge.
   task automatic one_cycle(input bit r, input bit f, input bit dbg, input bit uv,
                            input bit uc, input bit ut, input logic [31:0] upc,
                            input logic [31:0] vpc);
      int    li;
      int    c;
      bit    ev;
      exp_t  e;
      pend_t p;
      rst                   = r;
      bus.flush_i           = f;
      bus.debug_mode_i      = dbg;
      bus.upd_valid_i       = uv;
      bus.upd_conditional_i = uc;
      bus.upd_taken_i       = ut;
      bus.upd_pc_i          = upc;
      bus.vpc_i             = vpc;
      li = idx_of(vpc);
      ev = valid_m[li];
      c  = cnt_m[li];
`ifdef BHT_BYPASS_EN
      if (!r && !f && pend_q.size() > 0 && pend_q[0].at == cyc + 1 && pend_q[0].idx == li) begin
         ev = 1'b1;
         c  = sat(c, pend_q[0].taken);
      end
`endif
      e.r = (init_left == 0);
      e.v = e.r && ev;
      e.t = e.v && (c >= 2);
      exp_q.push_back(e);
      @(posedge clk);
      cyc++;
      if (r || f) begin
         model_clear();
      end else begin
         while (pend_q.size() > 0 && pend_q[0].at == cyc) begin
            p = pend_q.pop_front();
            cnt_m[p.idx]   = sat(cnt_m[p.idx], p.taken);
            valid_m[p.idx] = 1'b1;
         end
         if (init_left > 0) init_left--;
         else if (uv && uc && !dbg) begin
            p.at    = cyc + 1;
            p.idx   = idx_of(upc);
            p.taken = ut;
            pend_q.push_back(p);
         end
      end
      #1;
   endtask

   task automatic idle(input int n, input logic [31:0] vpc);
      for (int i = 0; i < n; i++) one_cycle(0, 0, 0, 0, 0, 0, 32'h0, vpc);
   endtask

   task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] vpc);
      one_cycle(0, 0, 0, 1, 1, t, pc, vpc);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (bus.ready_o !== e.r) begin
            errors++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, bus.ready_o, e.r);
         end
         checks++;
         if (bus.bht_valid_o !== e.v) begin
            errors++;
            $display("FAIL bht_valid cyc=%0d vpc=%h got=%b exp=%b", cyc, bus.vpc_i, bus.bht_valid_o, e.v);
         end
         checks++;
         if (bus.bht_taken_o !== e.t) begin
            errors++;
            $display("FAIL bht_taken cyc=%0d vpc=%h got=%b exp=%b", cyc, bus.vpc_i, bus.bht_taken_o, e.t);
         end
      end
   end

   initial begin
      logic [31:0] pool [8];
      logic [31:0] prev_pc;
      logic [31:0] upc;
      logic [31:0] vpc;
      rst = 1'b1;
      bus.flush_i = 1'b0;
      bus.debug_mode_i = 1'b0;
      bus.upd_valid_i = 1'b0;
      bus.upd_conditional_i = 1'b0;
      bus.upd_taken_i = 1'b0;
      bus.upd_pc_i = '0;
      bus.vpc_i = 32'h100;
      @(posedge clk);
      model_clear();
      #1;

      // reset sweep
      idle(68, 32'h100);

      // training 1->2->3, then back down to 1
      upd(32'h8000_0010, 1, 32'h8000_0010);
      upd(32'h8000_0010, 1, 32'h8000_0010);
      idle(3, 32'h8000_0010);
      upd(32'h8000_0010, 0, 32'h8000_0010);
      upd(32'h8000_0010, 0, 32'h8000_0010);
      idle(3, 32'h8000_0010);

      // saturation
      for (int i = 0; i < 5; i++) upd(32'h20, 1, 32'h20);
      upd(32'h20, 0, 32'h20);
      idle(2, 32'h20);
      for (int i = 0; i < 5; i++) upd(32'h20, 0, 32'h20);
      upd(32'h20, 1, 32'h20);
      idle(3, 32'h20);

      // filtering: unconditional, debug mode, during sweep
      one_cycle(0, 0, 0, 1, 0, 1, 32'h40, 32'h40);
      idle(3, 32'h40);
      one_cycle(0, 0, 1, 1, 1, 1, 32'h44, 32'h44);
      idle(3, 32'h44);
      one_cycle(0, 1, 0, 0, 0, 0, 32'h0, 32'h46);
      upd(32'h46, 1, 32'h46);
      idle(68, 32'h46);

      // flush mid-operation, then restart mid-sweep
      for (int i = 0; i < 3; i++) upd(32'h8, 1, 32'h8);
      idle(2, 32'h8);
      one_cycle(0, 1, 0, 1, 1, 1, 32'h8, 32'h8);
      idle(66, 32'h8);
      one_cycle(0, 1, 0, 0, 0, 0, 32'h0, 32'h8);
      idle(10, 32'h8);
      one_cycle(0, 1, 0, 0, 0, 0, 32'h0, 32'h8);
      idle(68, 32'h8);

      // aliasing at idx 1
      upd(32'h2, 1, 32'h2);
      idle(3, 32'h2);
      upd(32'h82, 1, 32'h2);
      idle(2, 32'h82);
      upd(32'h82, 0, 32'h2);
      idle(3, 32'h2);

      // randomized traffic
      for (int i = 0; i < 8; i++) pool[i] = $urandom;
      pool[1] = pool[0] ^ 32'h0000_0080;
      prev_pc = pool[0];
      for (int i = 0; i < 3000; i++) begin
         upc = pool[$urandom_range(0, 7)];
         vpc = ($urandom_range(0, 1) == 1) ? prev_pc : pool[$urandom_range(0, 7)];
         one_cycle($urandom_range(0, 599) == 0, $urandom_range(0, 249) == 0,
                   $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, upc, vpc);
         prev_pc = upc;
      end

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d exp=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
